// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC controller/reader pair: read-FSM states,
// result-word field layout and the default timing constants both sides agree on.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } rd_state_e;

  localparam int CH_MSB   = 31;
  localparam int CH_LSB   = 28;
  localparam int DATA_MSB = 27;
  localparam int CH_W     = CH_MSB - CH_LSB + 1;
  localparam int WORD_DW  = DATA_MSB + 1;

  localparam int TEST_TIME   = 1000;
  localparam int TEST_PERIOD = 25;
  localparam int FIFO_SIZE   = 8192;

  // Result word as seen by the FIFO: channel tag above the raw TDC value.
  function automatic logic [31:0] pack_word(input logic [CH_W-1:0] ch,
                                            input logic [WORD_DW-1:0] data);
    return {ch, data};
  endfunction

endpackage

// File: rtl/tdc_rd_cycle_timer.sv
// Phase-length down-counter for the TDC read strobe: loaded at the start of a
// low or high phase, it flags the final cycle of that phase.
module tdc_rd_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/tdc_result_reader.sv
// Burst reader for the TDC result registers: one strobe reads NUM_RESULTS
// registers over the asynchronous parallel bus and pushes channel-tagged words.
module tdc_result_reader
  import tdc_pkg::*;
#(
  parameter int NUM_RESULTS = 4,
  parameter int BASE_ADDR   = 8,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 28,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 2,
  parameter int FIFO_DEPTH  = FIFO_SIZE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_can_be_save,
  input  logic              master_rst,
  output logic [ADDR_W-1:0] tdc_addr,
  output logic              tdc_csn,
  output logic              tdc_rdn,
  input  logic [DATA_W-1:0] tdc_data,
  output logic              fifo_wr_en,
  output logic [31:0]       fifo_wr_data,
  input  logic              fifo_full,
  output logic              busy,
  output logic [31:0]       word_cnt,
  output logic [15:0]       drop_cnt,
  output logic              overrun
);

  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(RD_HIGH_CYC - 1);
  localparam logic [CH_W-1:0]  LAST_IDX  = CH_W'(NUM_RESULTS - 1);
  localparam logic [31:0]      WCNT_MAX  = 32'(FIFO_DEPTH - 1);

  rd_state_e         state_q;
  logic [CH_W-1:0]   idx_q;
  logic [ADDR_W-1:0] tdc_addr_q;
  logic              tdc_csn_q;
  logic              tdc_rdn_q;
  logic              fifo_wr_en_q;
  logic [31:0]       fifo_wr_data_q;
  logic              busy_q;
  logic [31:0]       word_cnt_q;
  logic [31:0]       word_cnt_d;
  logic [15:0]       drop_cnt_q;
  logic [15:0]       drop_cnt_d;
  logic              overrun_q;

  logic              tmr_load_s;
  logic [CNT_W-1:0]  tmr_val_s;
  logic              tmr_last_s;

  tdc_rd_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .last_o     (tmr_last_s)
  );

  // Timer reload: low phase armed from SETUP, high phase armed as STROBE ends.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = LOW_LOAD;
    if (state_q == ST_SETUP) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = LOW_LOAD;
    end else if ((state_q == ST_STROBE) && tmr_last_s) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = HIGH_LOAD;
    end else begin
      tmr_load_s = 1'b0;
      tmr_val_s  = LOW_LOAD;
    end
  end

  // Counter successors: word count wraps with the FIFO, drop count saturates.
  always_comb begin
    word_cnt_d = word_cnt_q + 32'd1;
    drop_cnt_d = drop_cnt_q;
    if (word_cnt_q == WCNT_MAX) begin
      word_cnt_d = 32'd0;
    end else begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
    if (drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Read FSM; every bus/FIFO output is set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      idx_q          <= {CH_W{1'b0}};
      tdc_addr_q     <= ADDR_W'(BASE_ADDR);
      tdc_csn_q      <= 1'b1;
      tdc_rdn_q      <= 1'b1;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= 32'd0;
      busy_q         <= 1'b0;
      word_cnt_q     <= 32'd0;
      drop_cnt_q     <= 16'd0;
      overrun_q      <= 1'b0;
    end else begin
      fifo_wr_en_q <= 1'b0;
      if (data_can_be_save && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (master_rst && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        tdc_csn_q <= 1'b1;
        tdc_rdn_q <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (data_can_be_save && !master_rst) begin
              state_q    <= ST_SETUP;
              idx_q      <= {CH_W{1'b0}};
              tdc_addr_q <= ADDR_W'(BASE_ADDR);
              tdc_csn_q  <= 1'b0;
              tdc_rdn_q  <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          ST_SETUP: begin
            state_q   <= ST_STROBE;
            tdc_rdn_q <= 1'b0;
          end
          ST_STROBE: begin
            if (tmr_last_s) begin
              state_q   <= ST_HOLD;
              tdc_rdn_q <= 1'b1;
              if (!fifo_full) begin
                fifo_wr_en_q   <= 1'b1;
                fifo_wr_data_q <= pack_word(idx_q, WORD_DW'(tdc_data));
                word_cnt_q     <= word_cnt_d;
              end else begin
                drop_cnt_q <= drop_cnt_d;
              end
            end
          end
          ST_HOLD: begin
            if (tmr_last_s) begin
              if (idx_q == LAST_IDX) begin
                state_q   <= ST_DONE;
                tdc_csn_q <= 1'b1;
              end else begin
                state_q    <= ST_SETUP;
                idx_q      <= idx_q + {{(CH_W-1){1'b0}}, 1'b1};
                tdc_addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q) + ADDR_W'(1);
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q   <= ST_IDLE;
            tdc_csn_q <= 1'b1;
            tdc_rdn_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tdc_addr     = tdc_addr_q;
  assign tdc_csn      = tdc_csn_q;
  assign tdc_rdn      = tdc_rdn_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign busy         = busy_q;
  assign word_cnt     = word_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_tdc_result_reader.sv
// Self-checking bench for tdc_result_reader: a frame-timeline model checked
// every cycle, plus literal expectations for the directed frames.
module tb_tdc_result_reader;

  localparam int N     = 4;
  localparam int L     = 3;
  localparam int H     = 2;
  localparam int P     = 1 + L + H;
  localparam int BASE  = 8;
  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_can_be_save = 1'b0;
  logic        master_rst = 1'b0;
  logic [3:0]  tdc_addr;
  logic        tdc_csn;
  logic        tdc_rdn;
  logic [27:0] tdc_data = 28'd0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic [31:0] word_cnt;
  logic [15:0] drop_cnt;
  logic        overrun;

  tdc_result_reader dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_can_be_save (data_can_be_save),
    .master_rst       (master_rst),
    .tdc_addr         (tdc_addr),
    .tdc_csn          (tdc_csn),
    .tdc_rdn          (tdc_rdn),
    .tdc_data         (tdc_data),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_full        (fifo_full),
    .busy             (busy),
    .word_cnt         (word_cnt),
    .drop_cnt         (drop_cnt),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // TDC chip stand-in: addressed pattern or random data, changed away from posedge.
  bit addr_mode = 1'b1;
  initial forever begin
    @(negedge clk);
    if (addr_mode) tdc_data = 28'h00000A0 + 28'(tdc_addr);
    else           tdc_data = 28'($urandom);
  end

  // Behavioural model: frame described as a timeline of N reads of P cycles plus DONE.
  int          edge_n = 0;
  int          m_start = 0;
  bit          m_act = 1'b0;
  int          m_word = 0;
  int          m_drop = 0;
  bit          m_over = 1'b0;
  bit          e_csn = 1'b1, e_rdn = 1'b1, e_busy = 1'b0, e_wen = 1'b0;
  logic [3:0]  e_addr = 4'(BASE);
  logic [31:0] e_wdata = 32'd0;

  initial forever begin
    int k, r, ph;
    @(posedge clk);
    edge_n++;
    if (!resetn) begin
      m_act = 1'b0; m_word = 0; m_drop = 0; m_over = 1'b0;
      e_csn = 1'b1; e_rdn = 1'b1; e_busy = 1'b0; e_wen = 1'b0;
      e_addr = 4'(BASE); e_wdata = 32'd0;
    end else begin
      e_wen = 1'b0;
      if (m_act) begin
        k = edge_n - m_start;
        if (data_can_be_save) m_over = 1'b1;
        if (master_rst) begin
          m_act = 1'b0;
        end else begin
          if (k <= N*P && ((k-1) % P) == L) begin
            r = (k-1) / P;
            if (!fifo_full) begin
              e_wen = 1'b1;
              e_wdata = {4'(r), tdc_data};
              m_word = (m_word + 1) % DEPTH;
            end else if (m_drop < 65535) begin
              m_drop++;
            end
          end
          if (k == N*P + 1) m_act = 1'b0;
        end
      end else if (data_can_be_save && !master_rst) begin
        m_act = 1'b1;
        m_start = edge_n;
      end
      if (m_act) begin
        k = edge_n + 1 - m_start;
        e_busy = 1'b1;
        if (k <= N*P) begin
          r = (k-1) / P;
          ph = (k-1) % P;
          e_csn = 1'b0;
          e_rdn = (ph >= 1 && ph <= L) ? 1'b0 : 1'b1;
          e_addr = 4'(BASE + r);
        end else begin
          e_csn = 1'b1;
          e_rdn = 1'b1;
        end
      end else begin
        e_busy = 1'b0; e_csn = 1'b1; e_rdn = 1'b1;
      end
    end
  end

  int          push_cyc[$];
  logic [31:0] push_data[$];
  logic [31:0] push_wcnt[$];
  bit          prev_wen = 1'b0;

  // Compare process: every cycle, DUT against the model, sampled at negedge.
  initial forever begin
    @(negedge clk);
    if (edge_n > 0) begin
      chk("csn", {31'd0, tdc_csn}, {31'd0, e_csn});
      chk("rdn", {31'd0, tdc_rdn}, {31'd0, e_rdn});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("addr", {28'd0, tdc_addr}, {28'd0, e_addr});
      chk("wr_en", {31'd0, fifo_wr_en}, {31'd0, e_wen});
      chk("word_cnt", word_cnt, 32'(m_word));
      chk("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
      chk("overrun", {31'd0, overrun}, {31'd0, m_over});
      if (e_wen) chk("wr_data", fifo_wr_data, e_wdata);
      if (!resetn) chk("wr_data_rst", fifo_wr_data, 32'd0);
      chk("wr_en_consec", {31'd0, prev_wen & fifo_wr_en}, 32'd0);
      prev_wen = fifo_wr_en;
      if (fifo_wr_en === 1'b1) begin
        push_cyc.push_back(edge_n + 1 - m_start);
        push_data.push_back(fifo_wr_data);
        push_wcnt.push_back(word_cnt);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; data_can_be_save = 1'b0; master_rst = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // One strobe in cycle 0, then ncyc cycles with optional full window, extra
  // strobe, master reset and bus reset at given frame-relative cycles.
  task automatic frame_run(input int ncyc, input int full_lo, input int full_hi,
                           input int s2_at, input int mr_at, input int rst_at);
    push_cyc.delete(); push_data.delete(); push_wcnt.delete();
    @(negedge clk);
    data_can_be_save = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (mr_at > 0 && c == mr_at + 1) begin
        chk("mr_csn", {31'd0, tdc_csn}, 32'd1);
        chk("mr_rdn", {31'd0, tdc_rdn}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_csn", {31'd0, tdc_csn}, 32'd1);
        chk("rst_rdn", {31'd0, tdc_rdn}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {28'd0, tdc_addr}, 32'd8);
        chk("rst_wdata", fifo_wr_data, 32'd0);
        chk("rst_wcnt", word_cnt, 32'd0);
      end
      data_can_be_save = (c == s2_at);
      master_rst = (c == mr_at);
      fifo_full = (c >= full_lo && c <= full_hi);
      resetn = !(c == rst_at);
    end
    data_can_be_save = 1'b0; master_rst = 1'b0; fifo_full = 1'b0; resetn = 1'b1;
  endtask

  logic [31:0] t1_data[4] = '{32'h0000_00A8, 32'h1000_00A9, 32'h2000_00AA, 32'h3000_00AB};
  int          t1_cyc[4]  = '{5, 11, 17, 23};
  logic [3:0]  t2_ch[3]   = '{4'd0, 4'd1, 4'd3};
  logic [31:0] tw_cnt[4]  = '{32'd8189, 32'd8190, 32'd8191, 32'd0};

  initial begin
    repeat (3) @(negedge clk);
    chk("init_csn", {31'd0, tdc_csn}, 32'd1);
    chk("init_rdn", {31'd0, tdc_rdn}, 32'd1);
    chk("init_addr", {28'd0, tdc_addr}, 32'd8);
    chk("init_wen", {31'd0, fifo_wr_en}, 32'd0);
    chk("init_wdata", fifo_wr_data, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_cnts", word_cnt | {16'd0, drop_cnt} | {31'd0, overrun}, 32'd0);
    resetn = 1'b1;

    // Plain frame.
    frame_run(30, 0, 0, 0, 0, 0);
    chk("t1_npush", 32'(push_data.size()), 32'd4);
    for (int i = 0; i < push_data.size() && i < 4; i++) begin
      chk("t1_data", push_data[i], t1_data[i]);
      chk("t1_cycle", 32'(push_cyc[i]), 32'(t1_cyc[i]));
    end
    chk("t1_wcnt", word_cnt, 32'd4);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // FIFO full during read 2.
    do_reset();
    frame_run(30, 13, 18, 0, 0, 0);
    chk("t2_npush", 32'(push_data.size()), 32'd3);
    for (int i = 0; i < push_data.size() && i < 3; i++)
      chk("t2_ch", {28'd0, push_data[i][31:28]}, {28'd0, t2_ch[i]});
    chk("t2_drop", {16'd0, drop_cnt}, 32'd1);
    chk("t2_wcnt", word_cnt, 32'd3);

    // Strobe while busy.
    do_reset();
    frame_run(30, 0, 0, 10, 0, 0);
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_npush", 32'(push_data.size()), 32'd4);
    chk("t3_wcnt", word_cnt, 32'd4);

    // Master reset mid-read 1.
    do_reset();
    frame_run(15, 0, 0, 0, 8, 0);
    chk("t4_npush", 32'(push_data.size()), 32'd1);
    chk("t4_wcnt", word_cnt, 32'd1);

    // Bus reset in STROBE, then a clean frame.
    do_reset();
    frame_run(10, 0, 0, 0, 0, 3);
    chk("t5_npush", 32'(push_data.size()), 32'd0);
    frame_run(30, 0, 0, 0, 0, 0);
    chk("t5_npush2", 32'(push_data.size()), 32'd4);
    if (push_data.size() > 0) begin
      chk("t5_first", push_data[0], 32'h0000_00A8);
      chk("t5_cycle", 32'(push_cyc[0]), 32'd5);
    end
    chk("t5_wcnt", word_cnt, 32'd4);

    // Randomized traffic against the model.
    do_reset();
    addr_mode = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      data_can_be_save = ($urandom_range(0, 19) == 0);
      master_rst = ($urandom_range(0, 149) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
    end
    data_can_be_save = 1'b0; master_rst = 1'b0; fifo_full = 1'b0;
    repeat (30) @(negedge clk);
    chk("rnd_idle", {31'd0, busy}, 32'd0);

    // Word counter wrap: 2047 back-to-back frames, then one more.
    do_reset();
    addr_mode = 1'b1;
    for (int f = 0; f < 2047; f++) frame_run(25, 0, 0, 0, 0, 0);
    chk("tw_pre", word_cnt, 32'd8188);
    frame_run(30, 0, 0, 0, 0, 0);
    chk("tw_npush", 32'(push_wcnt.size()), 32'd4);
    for (int i = 0; i < push_wcnt.size() && i < 4; i++)
      chk("tw_wcnt", push_wcnt[i], tw_cnt[i]);
    chk("tw_final", word_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
